// File: rtl/capture_pkg.sv
`default_nettype none
// ============================================================================
// Module      : capture_pkg
// Description : Shared state encoding, ASCII constants and helpers for the
//               capture sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package capture_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_FETCH   = 3'd2,
        ST_SEND    = 3'd3,
        ST_ARMED   = 3'd4
    } state_t;

    localparam logic [7:0] CMD_START  = 8'h53; // 'S'
    localparam logic [7:0] CMD_REDUMP = 8'h52; // 'R'
    localparam logic [7:0] CMD_ABORT  = 8'h41; // 'A'
    localparam logic [7:0] CMD_TRIG   = 8'h54; // 'T'
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_CR   = 8'h0D;

    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
        return (nib < 4'd10) ? ({4'h0, nib} + 8'h30) : ({4'h0, nib} + 8'h37);
    endfunction

    // Constants hold the uppercase letter; setting bit 5 gives the lowercase one.
    function automatic logic cmd_match(input logic [7:0] b, input logic [7:0] upper);
        return (b == upper) || (b == (upper | 8'h20));
    endfunction

endpackage
`default_nettype wire

// File: rtl/capture_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : capture_sequencer_if
// Description : Command, sample and TX byte-stream signals of the capture
//               sequencer. The sequencer uses the slave modport.
// Revision    : 1.0 - initial release
// ============================================================================
interface capture_sequencer_if #(
    parameter int SAMPLE_WIDTH = 24
);
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [7:0]              cmd_data;
    logic                    smp_valid;
    logic [SAMPLE_WIDTH-1:0] smp_data;
    logic                    tx_valid;
    logic                    tx_ready;
    logic [7:0]              tx_data;

    modport master (
        output cmd_valid, cmd_data, smp_valid, smp_data, tx_ready,
        input  cmd_ready, tx_valid, tx_data
    );

    modport slave (
        input  cmd_valid, cmd_data, smp_valid, smp_data, tx_ready,
        output cmd_ready, tx_valid, tx_data
    );
endinterface
`default_nettype wire

// File: rtl/capture_buffer.sv
`default_nettype none
// ============================================================================
// Module      : capture_buffer
// Description : Single-write / single-read synchronous RAM, one-cycle read
//               latency. The array has no reset.
// Revision    : 1.0 - initial release
// ============================================================================
module capture_buffer #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4096
) (
    input  wire logic                     clk,
    input  wire logic                     i_wr_en,
    input  wire logic [$clog2(DEPTH)-1:0] i_wr_addr,
    input  wire logic [WIDTH-1:0]         i_wr_data,
    input  wire logic                     i_rd_en,
    input  wire logic [$clog2(DEPTH)-1:0] i_rd_addr,
    output logic      [WIDTH-1:0]         o_rd_data
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;
endmodule
`default_nettype wire

// File: rtl/capture_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : capture_sequencer
// Description : Command-driven sample capture into a buffer, dumped as ASCII
//               hex lines on the TX byte stream. Define CAPTURE_TRIGGER_EN to
//               add the level-crossing armed trigger ('t' command).
// Revision    : 1.0 - initial release
// ============================================================================
module capture_sequencer
    import capture_pkg::*;
#(
    parameter int                      SAMPLE_WIDTH = 24,
    parameter int                      DEPTH        = 4096,
    parameter int                      GAP_CYCLES   = 0,
    parameter logic [SAMPLE_WIDTH-1:0] TRIG_LEVEL   = '0
) (
    input  wire logic        clk,
    input  wire logic        rst,
    capture_sequencer_if.slave bus,
    output logic [2:0]       state,
    output logic             buf_valid
);
    localparam int NIB   = SAMPLE_WIDTH / 4;
    localparam int AW    = $clog2(DEPTH);
    localparam int BCW   = $clog2(NIB + 2);
    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [AW-1:0]    LAST_IDX  = AW'(DEPTH - 1);
    localparam logic [BCW-1:0]   LAST_BYTE = BCW'(NIB + 1);
    localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'(GAP_CYCLES);

    state_t             r_state,      w_state_nxt;
    logic [AW-1:0]      r_index,      w_index_nxt;
    logic               r_buf_valid,  w_buf_valid_nxt;
    logic               r_cmd_ready;
    logic               r_tx_valid,   w_tx_valid_nxt;
    logic [7:0]         r_tx_data,    w_tx_data_nxt;
    logic [BCW-1:0]     r_byte_cnt,   w_byte_cnt_nxt;
    logic [GAP_W-1:0]   r_gap_cnt,    w_gap_cnt_nxt;
    logic               r_abort_pend, w_abort_pend_nxt;

    logic                    w_take, w_cmd_start, w_cmd_redump, w_cmd_abort;
    logic                    w_hs;
    logic                    w_wr_en, w_rd_en;
    logic [AW-1:0]           w_wr_addr;
    logic [SAMPLE_WIDTH-1:0] w_rd_data;
    logic [BCW-1:0]          w_char_idx;
    logic [3:0]              w_nib;
    logic [7:0]              w_char;

    assign w_take       = bus.cmd_valid && r_cmd_ready;
    assign w_cmd_start  = w_take && cmd_match(bus.cmd_data, CMD_START);
    assign w_cmd_redump = w_take && cmd_match(bus.cmd_data, CMD_REDUMP);
    assign w_cmd_abort  = w_take && cmd_match(bus.cmd_data, CMD_ABORT);
    assign w_hs         = r_tx_valid && bus.tx_ready;

`ifdef CAPTURE_TRIGGER_EN
    logic                    w_cmd_trig;
    logic [SAMPLE_WIDTH-1:0] r_prev,       w_prev_nxt;
    logic                    r_prev_valid, w_prev_valid_nxt;
    assign w_cmd_trig = w_take && cmd_match(bus.cmd_data, CMD_TRIG);
`else
    logic w_unused_trig;
    assign w_unused_trig = ^TRIG_LEVEL;
`endif

    capture_buffer #(
        .WIDTH (SAMPLE_WIDTH),
        .DEPTH (DEPTH)
    ) u_buffer (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (bus.smp_data),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (r_index),
        .o_rd_data (w_rd_data)
    );

    // Character for the byte being loaded: on a handshake the next one is
    // loaded immediately (back-to-back), otherwise the current one.
    always_comb begin
        w_char_idx = w_hs ? (r_byte_cnt + BCW'(1)) : r_byte_cnt;
        w_nib      = '0;
        for (int k = 0; k < NIB; k++) begin
            if (w_char_idx == BCW'(k)) begin
                w_nib = w_rd_data[4*(NIB-1-k) +: 4];
            end
        end
        if (w_char_idx == BCW'(NIB)) begin
            w_char = ASCII_LF;
        end else if (w_char_idx == LAST_BYTE) begin
            w_char = ASCII_CR;
        end else begin
            w_char = nibble_to_ascii(w_nib);
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_index_nxt      = r_index;
        w_buf_valid_nxt  = r_buf_valid;
        w_tx_valid_nxt   = r_tx_valid;
        w_tx_data_nxt    = r_tx_data;
        w_byte_cnt_nxt   = r_byte_cnt;
        w_gap_cnt_nxt    = (r_gap_cnt != '0) ? (r_gap_cnt - GAP_W'(1)) : r_gap_cnt;
        w_abort_pend_nxt = r_abort_pend;
        w_wr_en          = 1'b0;
        w_wr_addr        = r_index;
        w_rd_en          = 1'b0;
`ifdef CAPTURE_TRIGGER_EN
        w_prev_nxt       = r_prev;
        w_prev_valid_nxt = r_prev_valid;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_cmd_start) begin
                    w_buf_valid_nxt = 1'b0;
                    w_index_nxt     = '0;
                    w_state_nxt     = ST_CAPTURE;
                end else if (w_cmd_redump && r_buf_valid) begin
                    w_index_nxt = '0;
                    w_state_nxt = ST_FETCH;
                end
`ifdef CAPTURE_TRIGGER_EN
                else if (w_cmd_trig) begin
                    w_buf_valid_nxt  = 1'b0;
                    w_index_nxt      = '0;
                    w_prev_valid_nxt = 1'b0;
                    w_state_nxt      = ST_ARMED;
                end
`endif
            end
            ST_CAPTURE: begin
                if (w_cmd_abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (bus.smp_valid) begin
                    w_wr_en     = 1'b1;
                    w_index_nxt = r_index + AW'(1);
                    if (r_index == LAST_IDX) begin
                        w_buf_valid_nxt = 1'b1;
                        w_state_nxt     = ST_FETCH;
                    end
                end
            end
`ifdef CAPTURE_TRIGGER_EN
            ST_ARMED: begin
                if (w_cmd_abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (bus.smp_valid) begin
                    w_prev_nxt       = bus.smp_data;
                    w_prev_valid_nxt = 1'b1;
                    if (r_prev_valid && (r_prev < TRIG_LEVEL) && (bus.smp_data >= TRIG_LEVEL)) begin
                        w_wr_en     = 1'b1;
                        w_wr_addr   = '0;
                        w_index_nxt = AW'(1);
                        w_state_nxt = ST_CAPTURE;
                    end
                end
            end
`endif
            ST_FETCH: begin
                if (w_cmd_abort) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_rd_en        = 1'b1;
                    w_byte_cnt_nxt = '0;
                    w_state_nxt    = ST_SEND;
                end
            end
            ST_SEND: begin
                if (r_tx_valid) begin
                    if (w_hs) begin
                        if (r_abort_pend || w_cmd_abort) begin
                            w_tx_valid_nxt   = 1'b0;
                            w_gap_cnt_nxt    = GAP_LOAD;
                            w_abort_pend_nxt = 1'b0;
                            w_state_nxt      = ST_IDLE;
                        end else if (r_byte_cnt == LAST_BYTE) begin
                            w_tx_valid_nxt = 1'b0;
                            w_gap_cnt_nxt  = GAP_LOAD;
                            w_byte_cnt_nxt = '0;
                            if (r_index == LAST_IDX) begin
                                w_state_nxt = ST_IDLE;
                            end else begin
                                w_index_nxt = r_index + AW'(1);
                                w_state_nxt = ST_FETCH;
                            end
                        end else begin
                            w_byte_cnt_nxt = r_byte_cnt + BCW'(1);
                            if (GAP_CYCLES == 0) begin
                                w_tx_data_nxt = w_char;
                            end else begin
                                w_tx_valid_nxt = 1'b0;
                                w_gap_cnt_nxt  = GAP_LOAD;
                            end
                        end
                    end else if (w_cmd_abort) begin
                        // The byte on offer must still complete its handshake.
                        w_abort_pend_nxt = 1'b1;
                    end
                end else if (w_cmd_abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_gap_cnt == '0) begin
                    w_tx_valid_nxt = 1'b1;
                    w_tx_data_nxt  = w_char;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_index      <= '0;
            r_buf_valid  <= 1'b0;
            r_cmd_ready  <= 1'b0;
            r_tx_valid   <= 1'b0;
            r_tx_data    <= '0;
            r_byte_cnt   <= '0;
            r_gap_cnt    <= '0;
            r_abort_pend <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_index      <= w_index_nxt;
            r_buf_valid  <= w_buf_valid_nxt;
            r_cmd_ready  <= 1'b1;
            r_tx_valid   <= w_tx_valid_nxt;
            r_tx_data    <= w_tx_data_nxt;
            r_byte_cnt   <= w_byte_cnt_nxt;
            r_gap_cnt    <= w_gap_cnt_nxt;
            r_abort_pend <= w_abort_pend_nxt;
        end
    end

`ifdef CAPTURE_TRIGGER_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev       <= '0;
            r_prev_valid <= 1'b0;
        end else begin
            r_prev       <= w_prev_nxt;
            r_prev_valid <= w_prev_valid_nxt;
        end
    end
`endif

    assign bus.cmd_ready = r_cmd_ready;
    assign bus.tx_valid  = r_tx_valid;
    assign bus.tx_data   = r_tx_data;
    assign state         = r_state;
    assign buf_valid     = r_buf_valid;
endmodule
`default_nettype wire

// File: tb/tb_capture_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_capture_sequencer
// Description : Directed self-checking bench for capture_sequencer
//               (SAMPLE_WIDTH=24, DEPTH=4, GAP_CYCLES=0).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_capture_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] state;
    logic       buf_valid;
    logic       rdy_rand = 1'b0;
    logic       rdy_man  = 1'b1;
    logic       rnd_bit  = 1'b0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    logic [7:0] rx [$];
    int         n_total = 0;
    int         n_bad   = 0;

    capture_sequencer_if #(.SAMPLE_WIDTH(24)) bus ();

    capture_sequencer #(
        .SAMPLE_WIDTH (24),
        .DEPTH        (4),
        .GAP_CYCLES   (0),
        .TRIG_LEVEL   (24'h800000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state     (state),
        .buf_valid (buf_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1 rnd_bit = 1'($urandom_range(0, 1));
    end
    assign bus.tx_ready = rdy_rand ? rnd_bit : rdy_man;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Byte collector and stream-stability monitor.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", {31'd0, bus.tx_valid}, 32'd1);
                check("hold_data", {24'd0, bus.tx_data}, {24'd0, prev_data});
            end
            if (bus.tx_valid && bus.tx_ready) rx.push_back(bus.tx_data);
            prev_stall = bus.tx_valid && !bus.tx_ready;
            prev_data  = bus.tx_data;
        end
    end

    task automatic send_cmd(input logic [7:0] b);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = b;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic send_sample(input logic [23:0] v);
        repeat ($urandom_range(0, 3)) @(posedge clk);
        @(posedge clk); #1;
        bus.smp_valid = 1'b1;
        bus.smp_data  = v;
        @(posedge clk); #1;
        bus.smp_valid = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (state == s) break;
        end
        check(tag, {29'd0, state}, {29'd0, s});
    endtask

    task automatic wait_tx(input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.tx_valid) break;
        end
        check(tag, {31'd0, bus.tx_valid}, 32'd1);
    endtask

    task automatic check_stream(input string exp, input string tag);
        logic [7:0] got;
        check({tag, "_count"}, rx.size(), exp.len());
        for (int i = 0; i < exp.len(); i++) begin
            got = (i < rx.size()) ? rx[i] : 8'h00;
            check($sformatf("%s_byte%0d", tag, i), {24'd0, got}, {24'd0, exp[i]});
        end
    endtask

    task automatic feed_std;
        send_sample(24'h123456);
        send_sample(24'hABCDEF);
        send_sample(24'h000000);
        send_sample(24'hFFFFFF);
    endtask

    string exp_std = "123456\n\rABCDEF\n\r000000\n\rFFFFFF\n\r";

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = 8'h00;
        bus.smp_valid = 1'b0;
        bus.smp_data  = '0;

        // Reset state
        #3;
        check("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
        check("rst_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
        check("rst_tx_data", {24'd0, bus.tx_data}, 32'd0);
        check("rst_state", {29'd0, state}, 32'd0);
        check("rst_buf_valid", {31'd0, buf_valid}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rdy_before_edge", {31'd0, bus.cmd_ready}, 32'd0);
        @(negedge clk);
        check("rdy_after_edge", {31'd0, bus.cmd_ready}, 32'd1);

        // Basic capture and dump, tx_ready held high
        send_cmd("s");
        check("t1_capture", {29'd0, state}, 32'd1);
        send_sample(24'h123456);
        send_sample(24'hABCDEF);
        send_sample(24'h000000);
        send_sample(24'hFFFFFF);
        wait_tx(4, "t1_latency");
        wait_state(3'd0, 500, "t1_idle");
        check_stream(exp_std, "t1");
        check("t1_buf_valid", {31'd0, buf_valid}, 32'd1);
        repeat (3) @(negedge clk);
        rx.delete();

        // Same capture with random backpressure
        rdy_rand = 1'b1;
        send_cmd("S");
        feed_std();
        wait_state(3'd0, 1500, "t2_idle");
        rdy_rand = 1'b0;
        check_stream(exp_std, "t2");
        check("t2_buf_valid", {31'd0, buf_valid}, 32'd1);
        rx.delete();

        // Re-dump while samples keep arriving
        @(posedge clk); #1;
        bus.smp_valid = 1'b1;
        bus.smp_data  = 24'h555555;
        send_cmd("r");
        check("t3_fetch_or_send", {31'd0, 1'(state == 3'd2 || state == 3'd3)}, 32'd1);
        wait_state(3'd0, 500, "t3_idle");
        bus.smp_valid = 1'b0;
        check_stream(exp_std, "t3");
        rx.delete();

        // Abort mid-capture; redump then refused
        send_cmd("s");
        send_sample(24'h111111);
        send_sample(24'h222222);
        send_cmd("A");
        check("t4_state", {29'd0, state}, 32'd0);
        check("t4_buf_valid", {31'd0, buf_valid}, 32'd0);
        send_cmd("r");
        repeat (20) @(negedge clk);
        check("t4_state_r", {29'd0, state}, 32'd0);
        check("t4_no_bytes", rx.size(), 32'd0);

        // Commands ignored during a stalled SEND, then async reset
        rdy_man = 1'b0;
        send_cmd("s");
        feed_std();
        wait_tx(6, "t5_tx_up");
        send_cmd("s");
        send_cmd("x");
        check("t5_state", {29'd0, state}, 32'd3);
        check("t5_tx_valid", {31'd0, bus.tx_valid}, 32'd1);
        check("t5_tx_data", {24'd0, bus.tx_data}, 32'h31);
        check("t5_buf_valid", {31'd0, buf_valid}, 32'd1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
        check("t5_rst_state", {29'd0, state}, 32'd0);
        check("t5_rst_buf_valid", {31'd0, buf_valid}, 32'd0);
        check("t5_no_bytes", rx.size(), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);

        // Abort while a byte is stalled: the byte completes, then IDLE
        send_cmd("S");
        feed_std();
        wait_tx(6, "t6_tx_up");
        send_cmd("a");
        check("t6_held_state", {29'd0, state}, 32'd3);
        check("t6_held_valid", {31'd0, bus.tx_valid}, 32'd1);
        rdy_man = 1'b1;
        wait_state(3'd0, 10, "t6_idle");
        repeat (5) @(negedge clk);
        check_stream("1", "t6");
        check("t6_buf_valid", {31'd0, buf_valid}, 32'd1);
        rx.delete();

`ifdef CAPTURE_TRIGGER_EN
        // Armed trigger on rising crossing of 0x800000
        send_cmd("t");
        check("t7_armed", {29'd0, state}, 32'd4);
        send_sample(24'h100000);
        send_sample(24'h7FFFFF);
        check("t7_still_armed", {29'd0, state}, 32'd4);
        send_sample(24'h800000);
        check("t7_capture", {29'd0, state}, 32'd1);
        send_sample(24'h900000);
        send_sample(24'hA00000);
        send_sample(24'hB00000);
        wait_state(3'd0, 500, "t7_idle");
        check_stream("800000\n\r900000\n\rA00000\n\rB00000\n\r", "t7");
        rx.delete();
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/capture_sequencer.md
Name: capture_sequencer

Overview:
Command-driven controller that captures a block of converter samples into an internal buffer, then streams them out as ASCII hex lines on a byte stream feeding the UART transmitter. It sits between the sigma-delta ADC output (sample/valid), the UART RX byte stream (commands) and the UART TX byte stream. It replaces ad-hoc capture/dump logic in hardware-test tops.

Parameters:
SAMPLE_WIDTH, 24, sample width in bits; must be a multiple of 4; NIB = SAMPLE_WIDTH/4.
DEPTH, 4096, samples per capture; power of two, >= 2.
GAP_CYCLES, 0, minimum idle cycles with tx_valid low after each completed tx handshake.
TRIG_LEVEL, 0, unsigned trigger threshold; used only when CAPTURE_TRIGGER_EN is defined.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
cmd_valid  in  1  command byte valid (from UART RX)
cmd_ready  out  1  command byte accepted
cmd_data  in  8  command byte
smp_valid  in  1  one-cycle strobe: new sample
smp_data  in  SAMPLE_WIDTH  sample value
tx_valid  out  1  output byte valid (to UART TX)
tx_ready  in  1  UART TX can accept
tx_data  out  8  output ASCII byte
state  out  3  IDLE=0, CAPTURE=1, FETCH=2, SEND=3, ARMED=4
buf_valid  out  1  buffer holds a complete capture

Behaviour:
- Reset (async assert, sync release): cmd_ready=0, tx_valid=0, tx_data=0, state=IDLE, buf_valid=0, all counters 0. cmd_ready=1 from the first clock edge after release and is held at 1 thereafter. A command is taken when cmd_valid && cmd_ready.
- Commands are case-insensitive; any other byte is ignored:
  - 's'/'S': in IDLE, set buf_valid=0 and index=0, then go to CAPTURE. Ignored in all other states.
  - 'r'/'R': in IDLE with buf_valid=1, set index=0 and go to FETCH (re-dump). Ignored otherwise.
  - 'a'/'A': abort.
    - From CAPTURE/ARMED: go to IDLE and leave buf_valid=0.
    - From FETCH/SEND: if tx_valid=1, hold it until the handshake completes, then go to IDLE; otherwise go to IDLE immediately. buf_valid keeps its value.
- CAPTURE: each smp_valid writes smp_data to buffer[index] and increments index, which is $clog2(DEPTH) bits wide. On the write with index==DEPTH-1: set buf_valid=1, set index=0 (natural wrap), and go to FETCH. smp_valid every cycle is supported. smp_valid is ignored in all other states. If an abort command and the last sample arrive in the same cycle, abort wins and buf_valid stays 0.
- Buffer: synchronous read with 1-cycle latency.
  - FETCH presents index and latches the read word after one cycle, then enters SEND.
  - The first tx_valid rises no later than 3 cycles after the final sample write.
- SEND: emits NIB+2 bytes per sample: NIB hex characters MSB nibble first, then LF (0x0A), then CR (0x0D).
  - Hex encoding: nibble<10 gives nibble+0x30; otherwise nibble+0x37 (uppercase).
  - Stream rule: once tx_valid=1, tx_valid and tx_data stay stable until tx_ready=1. Never deassert valid without a handshake.
  - After each handshake, tx_valid stays low for at least GAP_CYCLES cycles (zero when GAP_CYCLES=0: back-to-back bytes are allowed).
  - After the CR handshake: if index==DEPTH-1, go to IDLE. Otherwise increment index and go to FETCH.
- Reset mid-operation: abandons everything immediately (tx_valid drops asynchronously) and clears buf_valid. Buffer RAM contents are undefined but are never emitted, because buf_valid=0.

Optional Feature:
CAPTURE_TRIGGER_EN
- Defined:
  - 't'/'T' in IDLE clears buf_valid and index and goes to ARMED.
  - ARMED registers the previous sample on every smp_valid. On the first smp_valid where prev<TRIG_LEVEL and smp_data>=TRIG_LEVEL (unsigned), that sample is written as buffer[0] and the state moves to CAPTURE with index=1.
  - The first sample after arming only initialises prev and can never fire the trigger.
- Undefined: the ARMED state and prev register are absent, 't' is ignored, and state never reads 4.

Decomposition:
- Package capture_pkg:
  - state enum (3-bit values above)
  - ASCII constants: CMD_START, CMD_REDUMP, CMD_ABORT, CMD_TRIG, ASCII_LF, ASCII_CR
  - function nibble_to_ascii(4-bit) -> 8-bit
- One sub-module, capture_buffer: 1-write/1-read synchronous RAM, parameters WIDTH and DEPTH, no reset on the array.

Test Plan:
- SAMPLE_WIDTH=24, DEPTH=4, tx_ready=1. Send 's', then samples 0x123456, 0xABCDEF, 0x000000, 0xFFFFFF with random gaps.
  -> Exactly 32 bytes: "123456\n\r" "ABCDEF\n\r" "000000\n\r" "FFFFFF\n\r". Then state=0 and buf_valid=1.
- Same run with tx_ready randomly toggled.
  -> Identical byte sequence; tx_data never changes while tx_valid=1 && tx_ready=0.
- Send 'r' after the first test with smp_valid driven throughout.
  -> Identical 32 bytes; buffer unchanged.
- Send 's', feed 2 samples, then 'A'.
  -> state=0, buf_valid=0, no tx bytes. A following 'r' is ignored (no output).
- Send 's' and 'x' during SEND; then assert rst with tx_valid=1, tx_ready=0.
  -> Commands have no effect on the stream. On reset, tx_valid drops the same cycle and state=0.
- CAPTURE_TRIGGER_EN, TRIG_LEVEL=0x800000. Send 't', feed 0x100000, 0x7FFFFF, 0x800000, 0x900000, 0xA00000, 0xB00000.
  -> Dump begins "800000\n\r"; the 0x100000 and 0x7FFFFF samples are not captured.
